hazard_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage RV32 core.
- Drives write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Handles three hazards: load-use stalls, MEM-stage taken branch/jump redirects, and variable-latency data-memory handshakes.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/hazard_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Central pipeline controller for the 5-stage RV32 core. It produces the
// write-enable and flush controls for the PC and the four pipeline registers.
// Three hazards are resolved here, highest priority first:
//   1. data-memory wait (variable-latency handshake) -> freeze the pipe
//   2. MEM-stage taken branch/jump                   -> redirect + flush
//   3. load-use dependency between EX and ID         -> stall IF/ID, bubble EX
// It also keeps saturating stall/flush counters and a sticky timeout flag.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   id_rs1/id_rs2, id_use_rs*   source registers of the ID instruction
//   ex_memread, ex_rd           load in EX and its destination
//   mem_taken, mem_pc_target    redirect request and target from MEM
//   mem_memread/mem_memwrite    MEM-stage memory operation
//   dmem_ready                  data memory completes the access this cycle
//   pc_write, pc_redirect,
//   pc_target                   PC enable / next-PC select / redirect target
//   *_write, *_flush            pipeline register enables and bubble inserts
//   dmem_req                    data memory request strobe
//   mem_timeout                 sticky: wait count reached MEM_TIMEOUT
//   stall_count, flush_count    saturating performance counters
// ---------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int CNT_WIDTH   = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4:0]            id_rs1,
   input  logic [4:0]            id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic                  ex_memread,
   input  logic [4:0]            ex_rd,
   input  logic                  mem_taken,
   input  logic [DATA_WIDTH-1:0] mem_pc_target,
   input  logic                  mem_memread,
   input  logic                  mem_memwrite,
   input  logic                  dmem_ready,
   output logic                  pc_write,
   output logic                  pc_redirect,
   output logic [DATA_WIDTH-1:0] pc_target,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic                  idex_write,
   output logic                  idex_flush,
   output logic                  exmem_write,
   output logic                  exmem_flush,
   output logic                  memwb_flush,
   output logic                  dmem_req,
   output logic                  mem_timeout,
   output logic [CNT_WIDTH-1:0]  stall_count,
   output logic [CNT_WIDTH-1:0]  flush_count
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [7:0]           TIMEOUT_LIM = 8'(MEM_TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};

   state_t               state_q, state_d;
   logic [7:0]           waitCnt_q, waitCnt_d;
   logic [7:0]           waitInc;
   logic                 timeout_q, timeout_d;
   logic [CNT_WIDTH-1:0] stallCount_q, stallCount_d;
   logic [CNT_WIDTH-1:0] flushCount_q, flushCount_d;

   logic memop;
   logic memFreeze;
   logic hazardHit;
   logic redirect;
   logic loadUse;

   // Hazard detection. The freeze covers both the first cycle a memory access
   // is seen without ready (still in RUN) and every non-ready MEM_WAIT cycle.
   // x0 is hard-wired zero, so a load targeting it can never create a hazard.
   assign memop     = mem_memread | mem_memwrite;
   assign memFreeze = (state_q == RUN) ? (memop & ~dmem_ready) : ~dmem_ready;
   assign hazardHit = ex_memread & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) |
                       (id_use_rs2 & (id_rs2 == ex_rd)));
   assign redirect  = ~memFreeze & mem_taken;
   assign loadUse   = ~memFreeze & ~mem_taken & hazardHit;
   assign waitInc   = (waitCnt_q == 8'hFF) ? 8'hFF : waitCnt_q + 8'd1;

   assign pc_target   = mem_pc_target;
   assign mem_timeout = timeout_q;
   assign stall_count = stallCount_q;
   assign flush_count = flushCount_q;

   // State, wait counter, sticky timeout and performance counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= RUN;
         waitCnt_q    <= 8'd0;
         timeout_q    <= 1'b0;
         stallCount_q <= '0;
         flushCount_q <= '0;
      end else begin
         state_q      <= state_d;
         waitCnt_q    <= waitCnt_d;
         timeout_q    <= timeout_d;
         stallCount_q <= stallCount_d;
         flushCount_q <= flushCount_d;
      end
   end

   // Next-state logic: MEM_WAIT is held until the memory reports ready; the
   // timeout flag is set once the running wait count reaches the limit.
   always_comb begin
      state_d      = state_q;
      waitCnt_d    = waitCnt_q;
      timeout_d    = timeout_q;
      stallCount_d = stallCount_q;
      flushCount_d = flushCount_q;
      case (state_q)
         RUN: begin
            if (memop & ~dmem_ready) begin
               state_d   = MEM_WAIT;
               waitCnt_d = 8'd1;
            end else begin
               waitCnt_d = 8'd0;
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               state_d   = RUN;
               waitCnt_d = 8'd0;
            end else begin
               waitCnt_d = waitInc;
               if (waitInc >= TIMEOUT_LIM) begin
                  timeout_d = 1'b1;
               end
            end
         end
         default: begin
            state_d   = RUN;
            waitCnt_d = 8'd0;
         end
      endcase
      if ((memFreeze | loadUse) && (stallCount_q != CNT_MAX)) begin
         stallCount_d = stallCount_q + CNT_WIDTH'(1);
      end
      if (redirect && (flushCount_q != CNT_MAX)) begin
         flushCount_d = flushCount_q + CNT_WIDTH'(1);
      end
   end

   // Pipeline controls. Reset overrides everything and bubbles every stage;
   // otherwise the freeze, redirect and load-use terms are already mutually
   // exclusive, so they can simply be combined.
   always_comb begin
      pc_write    = 1'b1;
      pc_redirect = 1'b0;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_write  = 1'b1;
      idex_flush  = 1'b0;
      exmem_write = 1'b1;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      dmem_req    = (state_q == MEM_WAIT) ? 1'b1 : memop;
      if (reset) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         exmem_write = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         memwb_flush = 1'b1;
         dmem_req    = 1'b0;
      end else if (memFreeze) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         exmem_write = 1'b0;
         memwb_flush = 1'b1;
      end else if (redirect) begin
         pc_redirect = 1'b1;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
      end else if (loadUse) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_flush  = 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl. Each cycle the stimulus is driven on
// the falling edge, a small behavioural model predicts the outputs, the
// prediction is pushed onto a scoreboard queue and then popped and compared
// against the DUT shortly afterwards. Counters are shrunk to 4 bits and the
// timeout to 4 cycles so saturation and timeout are reachable quickly.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int DW = 32;
   localparam int CW = 4;
   localparam int TO = 4;

   logic          clk;
   logic          reset;
   logic [4:0]    id_rs1, id_rs2, ex_rd;
   logic          id_use_rs1, id_use_rs2, ex_memread;
   logic          mem_taken, mem_memread, mem_memwrite, dmem_ready;
   logic [DW-1:0] mem_pc_target;
   logic          pc_write, pc_redirect, ifid_write, ifid_flush;
   logic          idex_write, idex_flush, exmem_write, exmem_flush;
   logic          memwb_flush, dmem_req, mem_timeout;
   logic [DW-1:0] pc_target;
   logic [CW-1:0] stall_count, flush_count;

   typedef struct packed {
      logic [9:0]    ctrl;
      logic [DW-1:0] tgt;
      logic          tmo;
      logic [CW-1:0] stall;
      logic [CW-1:0] flush;
   } exp_t;

   exp_t expQ[$];

   int testsRun  = 0;
   int failCount = 0;

   // Model state: 0 = RUN, 1 = MEM_WAIT
   logic          mState;
   int            mWait;
   logic          mTimeout;
   int            mStall;
   int            mFlush;

   hazard_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_memread(ex_memread), .ex_rd(ex_rd),
      .mem_taken(mem_taken), .mem_pc_target(mem_pc_target),
      .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
      .dmem_ready(dmem_ready),
      .pc_write(pc_write), .pc_redirect(pc_redirect), .pc_target(pc_target),
      .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_write(idex_write), .idex_flush(idex_flush),
      .exmem_write(exmem_write), .exmem_flush(exmem_flush),
      .memwb_flush(memwb_flush), .dmem_req(dmem_req),
      .mem_timeout(mem_timeout),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point; counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
      testsRun++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus, predict, enqueue, then dequeue and compare.
   task automatic applyStimulus(input logic rst, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic u1,
                                input logic u2, input logic exmr,
                                input logic [4:0] exrd, input logic taken,
                                input logic [DW-1:0] tgt, input logic mr,
                                input logic mw, input logic rdy);
      exp_t e;
      exp_t got;
      logic memop, frz, redir, lu, hz;
      logic pw, pr, iw, ifl, xw, xfl, ew, efl, wfl, req;
      int   nWait;
      @(negedge clk);
      reset = rst; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1;
      id_use_rs2 = u2; ex_memread = exmr; ex_rd = exrd; mem_taken = taken;
      mem_pc_target = tgt; mem_memread = mr; mem_memwrite = mw;
      dmem_ready = rdy;

      memop = mr | mw;
      frz   = mState ? !rdy : (memop && !rdy);
      hz    = exmr && (exrd != 0) && ((u1 && rs1 == exrd) || (u2 && rs2 == exrd));
      redir = !frz && taken;
      lu    = !frz && !taken && hz;
      if (rst) begin
         pw = 0; pr = 0; iw = 0; ifl = 1; xw = 0; xfl = 1;
         ew = 0; efl = 1; wfl = 1; req = 0;
      end else begin
         pw  = !frz && !lu;
         pr  = redir;
         iw  = !frz && !lu;
         ifl = redir;
         xw  = !frz;
         xfl = redir || lu;
         ew  = !frz;
         efl = redir;
         wfl = frz;
         req = mState ? 1'b1 : memop;
      end
      e.ctrl  = {pw, pr, iw, ifl, xw, xfl, ew, efl, wfl, req};
      e.tgt   = tgt;
      e.tmo   = mTimeout;
      e.stall = CW'(mStall);
      e.flush = CW'(mFlush);
      expQ.push_back(e);

      #1;
      got.ctrl  = {pc_write, pc_redirect, ifid_write, ifid_flush, idex_write,
                   idex_flush, exmem_write, exmem_flush, memwb_flush, dmem_req};
      got.tgt   = pc_target;
      got.tmo   = mem_timeout;
      got.stall = stall_count;
      got.flush = flush_count;
      e = expQ.pop_front();
      checkOutput("ctrl",        64'(got.ctrl),  64'(e.ctrl));
      checkOutput("pc_target",   64'(got.tgt),   64'(e.tgt));
      checkOutput("mem_timeout", 64'(got.tmo),   64'(e.tmo));
      checkOutput("stall_count", 64'(got.stall), 64'(e.stall));
      checkOutput("flush_count", 64'(got.flush), 64'(e.flush));

      // Advance the model to the state the DUT holds after the next edge
      if (rst) begin
         mState = 0; mWait = 0; mTimeout = 0; mStall = 0; mFlush = 0;
      end else begin
         if (!mState) begin
            if (memop && !rdy) begin mState = 1; mWait = 1; end
            else mWait = 0;
         end else if (rdy) begin
            mState = 0; mWait = 0;
         end else begin
            nWait = (mWait < 255) ? mWait + 1 : 255;
            mWait = nWait;
            if (nWait >= TO) mTimeout = 1;
         end
         if ((frz || lu) && mStall < (1 << CW) - 1) mStall++;
         if (redir && mFlush < (1 << CW) - 1) mFlush++;
      end
   endtask

   // Shorthand for a quiet cycle with no hazards
   task automatic idleCycle();
      applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 32'h0, 0, 0, 1);
   endtask

   initial begin
      reset = 1; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
      ex_memread = 0; ex_rd = 0; mem_taken = 0; mem_pc_target = 0;
      mem_memread = 0; mem_memwrite = 0; dmem_ready = 1;
      mState = 0; mWait = 0; mTimeout = 0; mStall = 0; mFlush = 0;
      // Settle state before the first checked cycle
      repeat (2) @(posedge clk);

      // Reset behaviour
      applyStimulus(1, 5'd3, 5'd4, 1, 1, 1, 5'd3, 1, 32'h100, 1, 0, 0);
      idleCycle();

      // Load-use on rs2, then x0 destination (no stall)
      applyStimulus(0, 5'd1, 5'd5, 0, 1, 1, 5'd5, 0, 32'h0, 0, 0, 1);
      idleCycle();
      checkOutput("stall_after_loaduse", 64'(stall_count), 64'd1);
      applyStimulus(0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 32'h0, 0, 0, 1);
      // Load-use on rs1, then matching rs1 that is not read
      applyStimulus(0, 5'd7, 5'd2, 1, 0, 1, 5'd7, 0, 32'h0, 0, 0, 1);
      applyStimulus(0, 5'd7, 5'd2, 0, 1, 1, 5'd7, 0, 32'h0, 0, 0, 1);
      idleCycle();
      checkOutput("stall_rs1", 64'(stall_count), 64'd2);

      // Redirect
      applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 32'h0000_0040, 0, 0, 1);
      idleCycle();
      checkOutput("flush_after_redirect", 64'(flush_count), 64'd1);

      // Memory wait: 3 cycles not ready, then ready
      repeat (3) applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 32'h0, 1, 0, 0);
      applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 32'h0, 1, 0, 1);
      idleCycle();
      checkOutput("stall_after_memwait", 64'(stall_count), 64'd5);

      // Priority: freeze hides redirect and load-use; release lets redirect win
      repeat (2) applyStimulus(0, 5'd9, 5'd0, 1, 0, 1, 5'd9, 1, 32'h0000_0080, 0, 1, 0);
      applyStimulus(0, 5'd9, 5'd0, 1, 0, 1, 5'd9, 1, 32'h0000_0080, 0, 1, 1);
      idleCycle();
      checkOutput("stall_priority", 64'(stall_count), 64'd7);
      checkOutput("flush_priority", 64'(flush_count), 64'd2);

      // Timeout: 6 cycles not ready, flag must stick after release
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 32'h0, 1, 0, 0);
         if (i == 3) checkOutput("timeout_early", 64'(mem_timeout), 64'd0);
      end
      checkOutput("timeout_set", 64'(mem_timeout), 64'd1);
      applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 32'h0, 1, 0, 1);
      idleCycle();
      checkOutput("timeout_sticky", 64'(mem_timeout), 64'd1);

      // Random traffic against the model
      for (int i = 0; i < 40; i++) begin
         applyStimulus(0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom), 1'($urandom), 1'($urandom),
                       5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
                       $urandom, 1'($urandom_range(0, 2) == 0),
                       1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
      end

      // Stall counter saturation
      repeat (16) applyStimulus(0, 5'd6, 5'd0, 1, 0, 1, 5'd6, 0, 32'h0, 0, 0, 1);
      idleCycle();
      checkOutput("stall_saturated", 64'(stall_count), 64'd15);

      // Reset arriving in MEM_WAIT
      repeat (2) applyStimulus(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 32'h0, 1, 0, 0);
      applyStimulus(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 32'h0, 1, 0, 0);
      idleCycle();
      checkOutput("reset_stall", 64'(stall_count), 64'd0);
      checkOutput("reset_flush", 64'(flush_count), 64'd0);
      checkOutput("reset_timeout", 64'(mem_timeout), 64'd0);
      checkOutput("reset_dmem_req", 64'(dmem_req), 64'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
